// File: rtl/rf_hazard_ctrl.sv
// RF-stage forwarding select and load-use hazard control with a two-slot EX/MEM shadow pipeline.
// Optional perf counters (stall_cycles, load_use_events) enabled by defining HAZARD_PERF_CNT_EN.
module rf_hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
`ifdef HAZARD_PERF_CNT_EN
    ,parameter int STALL_CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic [ADDR_W-1:0] id_rb,
    input  logic              id_uses_a,
    input  logic              id_uses_b,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              mem_wait,
    output logic              forwarding_a_en,
    output logic              forwarding_source_a,
    output logic              forwarding_b_en,
    output logic              forwarding_source_b,
    output logic              stall,
    output logic              ex_bubble
`ifdef HAZARD_PERF_CNT_EN
    ,output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] load_use_events
`endif
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    typedef enum logic [1:0] {RUN, LOAD_USE, MEM_WAIT} state_t;
    state_t state_q, state_d;

    // MEM slot keeps no load flag: nothing downstream of MEM needs it
    logic              ex_v, ex_wr, ex_ld, mem_v, mem_wr;
    logic [ADDR_W-1:0] ex_rd, mem_rd;
    logic              seen_valid;

    logic ex_a, ex_b, mem_a, mem_b;
    logic load_use, bubble_raw, active;

    function automatic logic hit(input logic v, input logic wr,
                                 input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] r);
        return v & wr & (rd == r) & (r != ZR);
    endfunction

    always_comb begin
        ex_a  = hit(ex_v, ex_wr, ex_rd, id_rn);
        ex_b  = hit(ex_v, ex_wr, ex_rd, id_rb);
        mem_a = hit(mem_v, mem_wr, mem_rd, id_rn);
        mem_b = hit(mem_v, mem_wr, mem_rd, id_rb);

        load_use   = id_valid & ~flush & ex_ld & ((id_uses_a & ex_a) | (id_uses_b & ex_b));
        bubble_raw = load_use | flush | ~id_valid;
        // Outputs stay quiet in reset and until the first instruction shows up
        active     = rst_n & (seen_valid | id_valid);

        forwarding_a_en     = 1'b0;
        forwarding_source_a = 1'b0;
        forwarding_b_en     = 1'b0;
        forwarding_source_b = 1'b0;
        if (active & id_valid & id_uses_a) begin
            if (ex_a & ~ex_ld) begin
                forwarding_a_en = 1'b1;
            end else if (mem_a) begin
                forwarding_a_en     = 1'b1;
                forwarding_source_a = 1'b1;
            end
        end
        if (active & id_valid & id_uses_b) begin
            if (ex_b & ~ex_ld) begin
                forwarding_b_en = 1'b1;
            end else if (mem_b) begin
                forwarding_b_en     = 1'b1;
                forwarding_source_b = 1'b1;
            end
        end

        stall     = active & (mem_wait | load_use);
        ex_bubble = active & ~mem_wait & bubble_raw;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mem_wait) state_d = MEM_WAIT;
                      else if (load_use) state_d = LOAD_USE;
            LOAD_USE: state_d = mem_wait ? MEM_WAIT : RUN;
            MEM_WAIT: if (!mem_wait) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            seen_valid <= 1'b0;
            ex_v       <= 1'b0;
            ex_wr      <= 1'b0;
            ex_ld      <= 1'b0;
            ex_rd      <= '0;
            mem_v      <= 1'b0;
            mem_wr     <= 1'b0;
            mem_rd     <= '0;
        end else begin
            state_q <= state_d;
            if (id_valid) seen_valid <= 1'b1;
            if (!mem_wait) begin
                mem_v  <= ex_v;
                mem_wr <= ex_wr;
                mem_rd <= ex_rd;
                ex_v   <= ~bubble_raw;
                ex_wr  <= ~bubble_raw & id_reg_write;
                ex_ld  <= ~bubble_raw & id_mem_read;
                ex_rd  <= id_rd;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles    <= '0;
            load_use_events <= '0;
        end else begin
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
            if (state_q == RUN && state_d == LOAD_USE && !(&load_use_events))
                load_use_events <= load_use_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Scoreboard bench for rf_hazard_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares {fa_en, fa_src, fb_en, fb_src, stall, ex_bubble}.
module tb_rf_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rn = '0, id_rb = '0, id_rd = '0;
    logic       id_uses_a = 1'b0, id_uses_b = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic       flush = 1'b0, mem_wait = 1'b0;
    logic       fa_en, fa_src, fb_en, fb_src, stall, ex_bubble;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, load_use_events;
`endif

    always #5 clk = ~clk;

    rf_hazard_ctrl #(.ADDR_W(5), .ZERO_REG(31)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .id_valid            (id_valid),
        .id_rn               (id_rn),
        .id_rb               (id_rb),
        .id_uses_a           (id_uses_a),
        .id_uses_b           (id_uses_b),
        .id_rd               (id_rd),
        .id_reg_write        (id_reg_write),
        .id_mem_read         (id_mem_read),
        .flush               (flush),
        .mem_wait            (mem_wait),
        .forwarding_a_en     (fa_en),
        .forwarding_source_a (fa_src),
        .forwarding_b_en     (fb_en),
        .forwarding_source_b (fb_src),
        .stall               (stall),
        .ex_bubble           (ex_bubble)
`ifdef HAZARD_PERF_CNT_EN
        ,.stall_cycles       (stall_cycles),
        .load_use_events     (load_use_events)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] exp;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // One vector per cycle: inputs change just after the rising edge.
    task automatic drive(input string nm, input logic rst, input logic v,
                         input logic [4:0] rn, input logic ua, input logic [4:0] rb, input logic ub,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic fl, input logic mw, input logic [5:0] exp);
        item_t it;
        @(posedge clk);
        #1;
        rst_n = rst; id_valid = v; id_rn = rn; id_uses_a = ua; id_rb = rb; id_uses_b = ub;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl; mem_wait = mw;
        it.name = nm;
        it.exp  = exp;
        q.push_back(it);
    endtask

    initial begin : monitor
        item_t      it;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it  = q.pop_front();
                act = {fa_en, fa_src, fb_en, fb_src, stall, ex_bubble};
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b (fa_en fa_src fb_en fb_src stall bubble)",
                             it.name, act, it.exp);
                end
            end
        end
    end

    initial begin : stim
        //                        rst v  rn    ua rb    ub rd    rw mr fl mw  expected
        drive("reset",            0, 1, 5'd1, 1, 5'd1, 1, 5'd1, 1, 1, 1, 1, 6'b000000);
        drive("idle_after_reset", 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 6'b000000);
        drive("add_x1",           1, 1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 0, 0, 6'b000000);
        drive("fwd_a_ex",         1, 1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 0, 0, 6'b100000);
        drive("add_x2_first",     1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 0, 6'b000000);
        drive("add_x2_second",    1, 1, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 0, 6'b000000);
        drive("fwd_b_ex_prio",    1, 1, 5'd0, 0, 5'd2, 1, 5'd10, 1, 0, 0, 0, 6'b001000);
        drive("fwd_a_ex_b_mem",   1, 1, 5'd10, 1, 5'd2, 1, 5'd0, 0, 0, 0, 0, 6'b101100);
        drive("wr_x31",           1, 1, 5'd0, 0, 5'd0, 0, 5'd31, 1, 0, 0, 0, 6'b000000);
        drive("ld_x31_read_x31",  1, 1, 5'd31, 1, 5'd31, 1, 5'd31, 1, 1, 0, 0, 6'b000000);
        drive("read_x31_no_lu",   1, 1, 5'd31, 1, 5'd31, 1, 5'd0, 0, 0, 0, 0, 6'b000000);
        drive("ldur_x3",          1, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0, 0, 6'b000000);
        drive("load_use_stall",   1, 1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0, 6'b000011);
        drive("load_use_fwd_mem", 1, 1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0, 6'b110000);
        drive("ldur_x5",          1, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, 6'b000000);
        drive("flush_masks_lu",   1, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 6'b000001);
        drive("after_flush_ex",   1, 1, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0, 0, 6'b110000);
        drive("ldur_x7",          1, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 6'b000000);
        for (int i = 0; i < 3; i++)
            drive("memwait_lu",   1, 1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 1, 6'b000010);
        drive("release_lu",       1, 1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 6'b000011);
        drive("release_fwd_mem",  1, 1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 6'b110000);
        drive("memwait_fwd_ex",   1, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 6'b100010);
        drive("reset_mid_stall",  0, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 6'b000000);
        drive("slots_cleared",    1, 1, 5'd8, 1, 5'd8, 1, 5'd0, 0, 0, 0, 0, 6'b000000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
